// File: rtl/bit_deser.sv
// Serial-to-word deserializer.
// Collects a frame of MSB-first serial bits into bytes, packs four bytes per
// 32-bit word (byte 0 in the top lane) and writes each word into a circular
// RAM window of BUF_WORDS words. Words that are only partly filled are padded
// with zeros and written when the frame ends. If the serial source stalls
// mid-frame, the frame is abandoned and err_o pulses.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_in; valid_in ignored
// RECV  | shifting bits, packing bytes, writing full words, gap watchdog
// FLUSH | writing a pending partial word (if any), then signalling done
// DONE  | done_o high for this single cycle, then back to IDLE
module bit_deser #(
  parameter int BUF_WORDS   = 256,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  input  logic [7:0]  length_in,
  input  logic        bit_in,
  input  logic        valid_in,
  output logic        ram_wr_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;

  localparam int              GAP_W     = $clog2(GAP_TIMEOUT + 1);
  localparam logic [31:0]     LAST_ADDR = 32'((BUF_WORDS - 1) * 4);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TIMEOUT - 1);

  state_t           state;
  logic [7:0]       len_q;
  logic [7:0]       byte_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift_q;
  logic [31:0]      word_q;
  logic [GAP_W-1:0] gap_cnt;

  logic [7:0]       new_byte;
  logic             byte_done;
  logic [1:0]       slot;
  logic [31:0]      word_next;
  logic [31:0]      addr_next;

  // Byte assembly, lane placement of the byte now completing, next RAM address
  always_comb begin
    new_byte  = {shift_q, bit_in};
    byte_done = valid_in && (bit_cnt == 3'd7);
    slot      = byte_cnt[1:0];
    word_next = word_q;
    case (slot)
      2'd0:    word_next[31:24] = new_byte;
      2'd1:    word_next[23:16] = new_byte;
      2'd2:    word_next[15:8]  = new_byte;
      default: word_next[7:0]   = new_byte;
    endcase
    addr_next = (ram_addr_o == LAST_ADDR) ? 32'd0 : ram_addr_o + 32'd4;
  end

  // Frame sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= 8'd0;
      byte_cnt   <= 8'd0;
      bit_cnt    <= 3'd0;
      shift_q    <= 7'd0;
      word_q     <= 32'd0;
      gap_cnt    <= '0;
      ram_wr_o   <= 1'b0;
      ram_addr_o <= 32'd0;
      ram_data_o <= 32'd0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      ram_wr_o <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;

      // the address of a write stays stable during its strobe, then steps on
      if (ram_wr_o) begin
        ram_addr_o <= addr_next;
      end

      case (state)
        IDLE: begin
          if (start_in) begin
            len_q      <= length_in;
            byte_cnt   <= 8'd0;
            bit_cnt    <= 3'd0;
            shift_q    <= 7'd0;
            word_q     <= 32'd0;
            gap_cnt    <= '0;
            ram_addr_o <= 32'd0;
            busy_o     <= 1'b1;
            if (length_in == 8'd0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state <= RECV;
            end
          end
        end

        RECV: begin
          if (valid_in) begin
            gap_cnt <= '0;
            shift_q <= new_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (byte_done) begin
              byte_cnt <= byte_cnt + 8'd1;
              if (slot == 2'd3) begin
                ram_wr_o   <= 1'b1;
                ram_data_o <= word_next;
                word_q     <= 32'd0;
              end else begin
                word_q <= word_next;
              end
              if (byte_cnt + 8'd1 == len_q) begin
                state <= FLUSH;
              end
            end
          end else if (gap_cnt == GAP_LAST) begin
            // source stalled: drop whatever is half-packed
            err_o   <= 1'b1;
            busy_o  <= 1'b0;
            word_q  <= 32'd0;
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        FLUSH: begin
          if (byte_cnt[1:0] != 2'd0) begin
            // partial word pending; clearing the lane count marks it written
            ram_wr_o      <= 1'b1;
            ram_data_o    <= word_q;
            word_q        <= 32'd0;
            byte_cnt[1:0] <= 2'd0;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end

        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
